// File: rtl/uart_tx.sv
// uart_tx: 8N1-style serial transmitter paced by a 16x oversampling baud tick
// Ports: clk (rising edge), reset_n (synchronous, active low), s_tick (one-clk 16x baud pulse),
//        tx_start (level-held request), tx_dato_in (byte, sampled on acceptance),
//        tx (serial line, idle high), tx_done (one-clk end-of-frame pulse), tx_busy (frame in progress)
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] tx_dato_in,
    output logic       tx,
    output logic       tx_done,
    output logic       tx_busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;
    logic [1:0] state, state_n;
    logic [4:0] s_cnt, s_n;
    logic [2:0] n_cnt, n_n;
    logic [7:0] b_reg, b_n;
    logic       armed, armed_n, done_n, tx_reg;
    assign tx = tx_reg;
    always_comb begin
        state_n = state;
        s_n     = s_cnt;
        n_n     = n_cnt;
        b_n     = b_reg;
        armed_n = armed;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                // armed forces tx_start to be seen low between frames, so a held request sends once
                if (!tx_start) armed_n = 1'b1;
                else if (armed) begin
                    b_n     = tx_dato_in;
                    s_n     = 5'd0;
                    armed_n = 1'b0;
                    state_n = START;
                end
            end
            START: if (s_tick) begin
                if (s_cnt == 5'd15) begin
                    s_n     = 5'd0;
                    n_n     = 3'd0;
                    state_n = DATA;
                end else s_n = s_cnt + 5'd1;
            end
            DATA: if (s_tick) begin
                if (s_cnt == 5'd15) begin
                    s_n = 5'd0;
                    b_n = b_reg >> 1;
                    if (n_cnt == 3'(DBIT - 1)) state_n = STOP;
                    else n_n = n_cnt + 3'd1;
                end else s_n = s_cnt + 5'd1;
            end
            STOP: if (s_tick) begin
                if (s_cnt == 5'(SB_TICK - 1)) begin
                    s_n     = 5'd0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else s_n = s_cnt + 5'd1;
            end
        endcase
    end
    // line and busy are derived from the next state so they change on the edge that enters it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            s_cnt   <= 5'd0;
            n_cnt   <= 3'd0;
            b_reg   <= 8'd0;
            armed   <= 1'b1;
            tx_reg  <= 1'b1;
            tx_done <= 1'b0;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_n;
            s_cnt   <= s_n;
            n_cnt   <= n_n;
            b_reg   <= b_n;
            armed   <= armed_n;
            tx_reg  <= (state_n == DATA) ? b_n[0] : (state_n != START);
            tx_done <= done_n;
            tx_busy <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx; stimulus queues expected frames, per-DUT monitors decode the line
module tb_uart_tx;
    typedef struct {
        logic [7:0] data;
        int         per;
        int         sb;
        int         start;
        int         abort_at;
    } exp_t;
    logic       clk = 0;
    logic       reset_n = 0;
    logic       st0 = 0, st1 = 0, div = 0;
    logic [7:0] dato = 8'h00;
    logic       s_tick;
    logic [1:0] tx_w, done_w, busy_w;
    int         cyc = 0;
    int         n_chk = 0, n_fail = 0;
    exp_t       q0[$], q1[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign s_tick = div ? (cyc % 4 == 3) : 1'b1;
    uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(st0), .tx_dato_in(dato),
        .tx(tx_w[0]), .tx_done(done_w[0]), .tx_busy(busy_w[0])
    );
    uart_tx #(.DBIT(8), .SB_TICK(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(st1), .tx_dato_in(dato),
        .tx(tx_w[1]), .tx_done(done_w[1]), .tx_busy(busy_w[1])
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask
    task automatic mon(input int u);
        logic       prev = 1'b1;
        logic [7:0] dec;
        logic       etx;
        exp_t       e;
        int         p, len, bad, first, qs;
        forever begin
            @(negedge clk);
            if (prev && !tx_w[u]) begin
                qs = u ? q1.size() : q0.size();
                if (qs == 0) begin
                    chk($sformatf("u%0d unexpected frame at cycle %0d", u, cyc), 1, 0);
                    for (int k = 0; k < 3000 && !done_w[u] && reset_n; k++) @(negedge clk);
                end else begin
                    if (u == 1) e = q1.pop_front();
                    else e = q0.pop_front();
                    chk($sformatf("u%0d byte %0h start cycle", u, e.data), cyc, e.start);
                    p = e.per;
                    len = p * (144 + e.sb);
                    bad = 0;
                    first = -1;
                    dec = 8'h00;
                    for (int i = 0; i <= len; i++) begin
                        if (i > 0) @(negedge clk);
                        if (i == e.abort_at) begin
                            chk($sformatf("u%0d reset tx", u), tx_w[u], 1);
                            chk($sformatf("u%0d reset busy", u), busy_w[u], 0);
                            chk($sformatf("u%0d reset done", u), done_w[u], 0);
                            break;
                        end
                        etx = (i < 16 * p) ? 1'b0 : (i < 144 * p) ? e.data[(i - 16 * p) / (16 * p)] : 1'b1;
                        if (tx_w[u] !== etx || done_w[u] !== (i == len) || busy_w[u] !== (i < len)) begin
                            bad++;
                            if (first < 0) first = i;
                        end
                        if (i >= 16 * p && i < 144 * p && (i - 16 * p) % (16 * p) == 8 * p)
                            dec[(i - 16 * p) / (16 * p)] = tx_w[u];
                    end
                    if (e.abort_at < 0) chk($sformatf("u%0d decoded byte", u), dec, e.data);
                    chk($sformatf("u%0d byte %0h bad samples (first at %0d)", u, e.data, first), bad, 0);
                end
            end
            prev = tx_w[u];
        end
    endtask
    initial mon(0);
    initial mon(1);
    task automatic send(input int u, input logic [7:0] d, input int per, input int sb, input int ab);
        exp_t e;
        e.data = d;
        e.per = per;
        e.sb = sb;
        e.start = cyc + 1;
        e.abort_at = ab;
        if (u == 1) q1.push_back(e);
        else q0.push_back(e);
        dato = d;
        if (u == 1) st1 = 1'b1;
        else st0 = 1'b1;
    endtask
    task automatic wait_done(input int u, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done_w[u]) break;
        end
        chk($sformatf("u%0d tx_done seen", u), done_w[u], 1);
        @(posedge clk);
        #1;
        if (u == 1) st1 = 1'b0;
        else st0 = 1'b0;
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        step(3);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d reset tx", u), tx_w[u], 1);
            chk($sformatf("u%0d reset busy", u), busy_w[u], 0);
            chk($sformatf("u%0d reset done", u), done_w[u], 0);
        end
        step(1);
        reset_n = 1'b1;
        step(5);
        send(0, 8'h70, 1, 16, -1);
        wait_done(0, 400);
        step(20);
        div = 1'b1;
        for (int i = 0; i < 8 && cyc % 4 != 3; i++) step(1);
        send(0, 8'h30, 4, 16, -1);
        wait_done(0, 1000);
        div = 1'b0;
        step(20);
        send(0, 8'h55, 1, 16, -1);
        step(400);
        st0 = 1'b0;
        step(1);
        send(0, 8'hC3, 1, 16, -1);
        wait_done(0, 400);
        step(20);
        send(0, 8'hA5, 1, 16, -1);
        step(30);
        dato = 8'h00;
        wait_done(0, 400);
        step(20);
        send(0, 8'h3C, 1, 16, 70);
        step(70);
        reset_n = 1'b0;
        st0 = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(10);
        send(0, 8'hFF, 1, 16, -1);
        wait_done(0, 400);
        step(20);
        send(1, 8'h00, 1, 32, -1);
        wait_done(1, 400);
        step(50);
        chk("u0 frames left in queue", q0.size(), 0);
        chk("u1 frames left in queue", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
